// File: rtl/fib_lookup_ctrl_pkg.sv
// Shared FIB constants, lookup state encoding and the result record.
// Used by both the lookup controller and the level blocks.
package fib_pkg;
  localparam int WORD_SIZE       = 32;
  localparam int POINTER_SIZE    = 16;
  localparam int MAX_NAME_LENGTH = 16;
  localparam int LEN_W           = $clog2(MAX_NAME_LENGTH + 1);
  localparam int IDX_W           = $clog2(MAX_NAME_LENGTH);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_PROBE   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } fib_lookup_state_e;

  typedef struct packed {
    logic [LEN_W-1:0]        match_len;
    logic [POINTER_SIZE-1:0] pointer;
    logic                    timeout;
  } fib_result_t;
endpackage

// File: rtl/fib_lookup_ctrl_if.sv
// Name stream, level probe bus and result bus of the FIB lookup controller.
// master = the controller, slave = parser / level memory / result consumer.
interface fib_lookup_ctrl_if;
  import fib_pkg::*;

  logic [WORD_SIZE-1:0]    name_word_in;
  logic                    name_valid_in;
  logic                    name_last_in;
  logic                    name_ready_out;
  logic [POINTER_SIZE-1:0] level_address_out;
  logic [WORD_SIZE-1:0]    level_lookup_cont_out;
  logic [POINTER_SIZE-1:0] level_next_pointer_in;
  logic                    level_is_match_in;
  logic                    level_no_child_in;
  logic                    result_valid_out;
  logic                    result_ready_in;
  logic [LEN_W-1:0]        result_match_len_out;
  logic [POINTER_SIZE-1:0] result_pointer_out;
  logic                    result_timeout_out;
  logic                    busy_out;

  modport master (
    input  name_word_in, name_valid_in, name_last_in,
    output name_ready_out,
    output level_address_out, level_lookup_cont_out,
    input  level_next_pointer_in, level_is_match_in, level_no_child_in,
    output result_valid_out,
    input  result_ready_in,
    output result_match_len_out, result_pointer_out, result_timeout_out,
    output busy_out
  );

  modport slave (
    output name_word_in, name_valid_in, name_last_in,
    input  name_ready_out,
    input  level_address_out, level_lookup_cont_out,
    output level_next_pointer_in, level_is_match_in, level_no_child_in,
    input  result_valid_out,
    output result_ready_in,
    input  result_match_len_out, result_pointer_out, result_timeout_out,
    input  busy_out
  );
endinterface

// File: rtl/fib_lookup_ctrl_name_buffer.sv
// Holds one NDN name as up to MAX_NAME_LENGTH words; words past the limit are dropped.
module fib_name_buffer
  import fib_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 wr_en,
  input  logic                 wr_first,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic [LEN_W-1:0]     stored_len
);
  logic [WORD_SIZE-1:0] mem [MAX_NAME_LENGTH];
  logic [LEN_W-1:0]     count;
  logic [IDX_W-1:0]     wr_idx;
  logic                 do_write;

  // the first word of a name restarts the buffer regardless of the old count
  assign wr_idx   = wr_first ? '0 : count[IDX_W-1:0];
  assign do_write = wr_en && (wr_first || (count < LEN_W'(MAX_NAME_LENGTH)));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count <= '0;
    end else if (wr_en && wr_first) begin
      count <= LEN_W'(1);
    end else if (do_write) begin
      count <= count + LEN_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_write) mem[wr_idx] <= wr_data;
  end

  assign rd_data    = mem[rd_idx];
  assign stored_len = count;
endmodule

// File: rtl/fib_lookup_ctrl.sv
// FIB lookup initiator: buffers a name, walks the tree one probe at a time, reports the longest match.
// FIB_LOOKUP_STATS_EN adds lookup/probe statistics counters.
//  state   | meaning
//  IDLE    | waiting for the first name word
//  LOAD    | receiving remaining name words
//  PROBE   | address/word presented to the level
//  CAPTURE | level response sampled, next step decided
//  RESP    | result held until accepted
module fib_lookup_ctrl
  import fib_pkg::*;
#(
  parameter logic [POINTER_SIZE-1:0] ROOT_PTR   = '0,
  parameter int                      MAX_PROBES = 64
) (
  input  logic               clk_in,
  input  logic               rst_in,
  fib_lookup_ctrl_if.master  bus
`ifdef FIB_LOOKUP_STATS_EN
  ,
  output logic [31:0]        stat_lookups_out,
  output logic [31:0]        stat_probes_out
`endif
);
  localparam int PC_W = $clog2(MAX_PROBES + 1);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_LOAD    = ST_LOAD;
  localparam logic [2:0] S_PROBE   = ST_PROBE;
  localparam logic [2:0] S_CAPTURE = ST_CAPTURE;
  localparam logic [2:0] S_RESP    = ST_RESP;

  logic [2:0]              state;
  logic                    ready_q;
  logic [POINTER_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0]    lookup_q;
  logic [IDX_W-1:0]        word_idx;
  logic [LEN_W-1:0]        match_len;
  logic [LEN_W-1:0]        len_inc;
  logic [POINTER_SIZE-1:0] ptr_q;
  logic [PC_W-1:0]         probe_cnt;
  logic [PC_W-1:0]         probe_cnt_nxt;
  fib_result_t             result_q;
  logic                    result_valid_q;
  logic                    name_xfer;
  logic                    last_word;
  logic                    probe_limit;
  logic [IDX_W-1:0]        rd_idx;
  logic [WORD_SIZE-1:0]    rd_word;
  logic [LEN_W-1:0]        stored_len;

  assign name_xfer     = bus.name_valid_in && ready_q;
  assign probe_cnt_nxt = probe_cnt + PC_W'(1);
  assign probe_limit   = (probe_cnt_nxt == PC_W'(MAX_PROBES));
  assign last_word     = ((LEN_W'(word_idx) + LEN_W'(1)) == stored_len);
  assign len_inc       = (match_len == LEN_W'(MAX_NAME_LENGTH)) ? match_len : match_len + LEN_W'(1);
  // during CAPTURE the buffer is already addressed at the word a match would advance to
  assign rd_idx        = (state == S_CAPTURE) ? word_idx + IDX_W'(1) : '0;

  fib_name_buffer u_name_buffer (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .wr_en      (name_xfer),
    .wr_first   (name_xfer && (state == S_IDLE)),
    .wr_data    (bus.name_word_in),
    .rd_idx     (rd_idx),
    .rd_data    (rd_word),
    .stored_len (stored_len)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= S_IDLE;
      ready_q        <= 1'b0;
      addr_q         <= '0;
      lookup_q       <= '0;
      word_idx       <= '0;
      match_len      <= '0;
      ptr_q          <= '0;
      probe_cnt      <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_LOAD: begin
          ready_q <= 1'b1;
          if (name_xfer) begin
            if (bus.name_last_in) begin
              state     <= S_PROBE;
              ready_q   <= 1'b0;
              addr_q    <= ROOT_PTR;
              lookup_q  <= (state == S_IDLE) ? bus.name_word_in : rd_word;
              word_idx  <= '0;
              match_len <= '0;
              ptr_q     <= '0;
              probe_cnt <= '0;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_PROBE: state <= S_CAPTURE;
        S_CAPTURE: begin
          probe_cnt <= probe_cnt_nxt;
          if (bus.level_is_match_in) begin
            match_len <= len_inc;
            ptr_q     <= addr_q;
            if (last_word || probe_limit) begin
              result_q       <= '{match_len: len_inc, pointer: addr_q, timeout: !last_word};
              result_valid_q <= 1'b1;
              state          <= S_RESP;
            end else begin
              word_idx <= word_idx + IDX_W'(1);
              addr_q   <= bus.level_next_pointer_in;
              lookup_q <= rd_word;
              state    <= S_PROBE;
            end
          end else if (bus.level_no_child_in || probe_limit) begin
            result_q       <= '{match_len: match_len, pointer: ptr_q, timeout: !bus.level_no_child_in};
            result_valid_q <= 1'b1;
            state          <= S_RESP;
          end else begin
            addr_q <= bus.level_next_pointer_in;
            state  <= S_PROBE;
          end
        end
        S_RESP: begin
          if (bus.result_ready_in) begin
            result_valid_q <= 1'b0;
            ready_q        <= 1'b1;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FIB_LOOKUP_STATS_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stat_lookups_out <= '0;
      stat_probes_out  <= '0;
    end else begin
      if ((state == S_RESP) && bus.result_ready_in) stat_lookups_out <= stat_lookups_out + 32'd1;
      if (state == S_CAPTURE)                       stat_probes_out  <= stat_probes_out + 32'd1;
    end
  end
`endif

  assign bus.name_ready_out        = ready_q;
  assign bus.level_address_out     = addr_q;
  assign bus.level_lookup_cont_out = lookup_q;
  assign bus.result_valid_out      = result_valid_q;
  assign bus.result_match_len_out  = result_q.match_len;
  assign bus.result_pointer_out    = result_q.pointer;
  assign bus.result_timeout_out    = result_q.timeout;
  assign bus.busy_out              = (state == S_PROBE) || (state == S_CAPTURE) || (state == S_RESP);
endmodule

// File: tb/tb_fib_lookup_ctrl.sv
// Bench for fib_lookup_ctrl: behavioural tree/level model, reference walk and per-cycle result compare.
module tb_fib_lookup_ctrl;
  import fib_pkg::*;

  localparam int MAXP = 8;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  fib_lookup_ctrl_if bus ();
`ifdef FIB_LOOKUP_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_probes;
`endif

  fib_lookup_ctrl #(.ROOT_PTR(16'd0), .MAX_PROBES(MAXP)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
`ifdef FIB_LOOKUP_STATS_EN
    ,
    .stat_lookups_out (stat_lookups),
    .stat_probes_out  (stat_probes)
`endif
  );

  int total = 0;
  int bad   = 0;
  int accepted_since_rst = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // tree held as plain arrays; a node matches when its word equals the probed word
  logic [31:0] node_word    [256];
  logic [15:0] node_next    [256];
  bit          node_nochild [256];
  bit          lvl_never = 1'b0;
  logic [31:0] name_buf     [24];
  fib_result_t exp_q [$];

  // level: one-cycle registered response to whatever address/word is presented
  always @(posedge clk_in) begin
    bus.level_is_match_in     <= !lvl_never && (node_word[bus.level_address_out[7:0]] == bus.level_lookup_cont_out);
    bus.level_no_child_in     <= !lvl_never && node_nochild[bus.level_address_out[7:0]];
    bus.level_next_pointer_in <= lvl_never ? bus.level_address_out + 16'd1
                                           : node_next[bus.level_address_out[7:0]];
  end

  // reference walk: at most MAXP probes; an unfinished walk is a timeout
  function automatic fib_result_t ref_lookup(input int n);
    int stored, i, len, addr, ptr;
    bit done, m;
    fib_result_t r;
    stored = (n > MAX_NAME_LENGTH) ? MAX_NAME_LENGTH : n;
    i = 0; len = 0; addr = 0; ptr = 0; done = 1'b0;
    for (int p = 0; p < MAXP; p++) begin
      if (!done) begin
        m = !lvl_never && (node_word[addr & 255] == name_buf[i]);
        if (m) begin
          len++;
          ptr = addr;
          if (i == stored - 1) done = 1'b1;
          else begin
            i++;
            addr = node_next[addr & 255];
          end
        end else if (!lvl_never && node_nochild[addr & 255]) begin
          done = 1'b1;
        end else begin
          addr = lvl_never ? addr + 1 : int'(node_next[addr & 255]);
        end
      end
    end
    r.match_len = LEN_W'(len);
    r.pointer   = 16'(ptr);
    r.timeout   = !done;
    return r;
  endfunction

  // compare process: every cycle a result is presented it must equal the oldest expectation
  always @(negedge clk_in) begin
    if (!rst_in && bus.result_valid_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        check("match_len", bus.result_match_len_out, exp_q[0].match_len);
        check("pointer", bus.result_pointer_out, exp_q[0].pointer);
        check("timeout", bus.result_timeout_out, exp_q[0].timeout);
        check("name_ready_in_resp", bus.name_ready_out, 0);
        check("busy_in_resp", bus.busy_out, 1);
        if (bus.result_ready_in) exp_q.delete(0);
      end
    end
  end

  task automatic clear_tree();
    for (int a = 0; a < 256; a++) begin
      node_word[a]    = 32'hFFFF_FFFF;
      node_next[a]    = 16'd0;
      node_nochild[a] = 1'b0;
    end
    lvl_never = 1'b0;
  endtask

  task automatic send_name(input int n, input bit gaps);
    int guard;
    bit rdy;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk_in); #1; end
      bus.name_valid_in = 1'b1;
      bus.name_word_in  = name_buf[i];
      bus.name_last_in  = (i == n - 1);
      guard = 0;
      do begin
        @(negedge clk_in);
        rdy = bus.name_ready_out;
        @(posedge clk_in); #1;
        guard++;
      end while (!rdy && guard < 50);
      if (!rdy) check("name_accept_wait", 0, 1);
      bus.name_valid_in = 1'b0;
      bus.name_last_in  = 1'b0;
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.result_valid_out && cyc < 200) begin @(posedge clk_in); #1; cyc++; end
  endtask

  task automatic accept_result(input int hold);
    int cyc;
    wait_valid(cyc);
    if (!bus.result_valid_out) begin
      check("result_wait", 0, 1);
      exp_q.delete();
      return;
    end
    repeat (hold) begin @(posedge clk_in); #1; end
    bus.result_ready_in = 1'b1;
    @(posedge clk_in); #1;
    bus.result_ready_in = 1'b0;
    accepted_since_rst++;
    check("valid_after_accept", bus.result_valid_out, 0);
    check("busy_after_accept", bus.busy_out, 0);
    check("ready_after_accept", bus.name_ready_out, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_name_ready"}, bus.name_ready_out, 0);
    check({tag, "_level_addr"}, bus.level_address_out, 0);
    check({tag, "_level_word"}, bus.level_lookup_cont_out, 0);
    check({tag, "_valid"}, bus.result_valid_out, 0);
    check({tag, "_len"}, bus.result_match_len_out, 0);
    check({tag, "_ptr"}, bus.result_pointer_out, 0);
    check({tag, "_timeout"}, bus.result_timeout_out, 0);
    check({tag, "_busy"}, bus.busy_out, 0);
`ifdef FIB_LOOKUP_STATS_EN
    check({tag, "_stat_lookups"}, stat_lookups, 0);
    check({tag, "_stat_probes"}, stat_probes, 0);
`endif
  endtask

  task automatic tree_three_words();
    clear_tree();
    node_word[0] = 32'h100; node_next[0] = 16'd5;
    node_word[5] = 32'h101; node_next[5] = 16'd9;
    node_word[9] = 32'h999; node_nochild[9] = 1'b1;
    name_buf[0] = 32'h100; name_buf[1] = 32'h101; name_buf[2] = 32'h102;
  endtask

  initial begin
    fib_result_t e;
    int cyc;
    bus.name_word_in    = '0;
    bus.name_valid_in   = 1'b0;
    bus.name_last_in    = 1'b0;
    bus.result_ready_in = 1'b0;
    clear_tree();

    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk_in);
    #1; rst_in = 1'b0;
    @(posedge clk_in); #1;
    check("ready_after_reset", bus.name_ready_out, 1);

    // 1: single word matching the root
    clear_tree();
    node_word[0] = 32'hA; node_next[0] = 16'd3;
    name_buf[0] = 32'hA;
    e = ref_lookup(1);
    check("pin1_len", e.match_len, 1); check("pin1_ptr", e.pointer, 0); check("pin1_to", e.timeout, 0);
    exp_q.push_back(e);
    send_name(1, 1'b0);
    accept_result(0);

    // 2: three words, two match, third hits a childless mismatch
    tree_three_words();
    e = ref_lookup(3);
    check("pin2_len", e.match_len, 2); check("pin2_ptr", e.pointer, 5); check("pin2_to", e.timeout, 0);
    exp_q.push_back(e);
    send_name(3, 1'b0);
    accept_result(0);

    // 3: root mismatch with no child; result right after the single probe
    clear_tree();
    node_word[0] = 32'h1; node_nochild[0] = 1'b1;
    name_buf[0] = 32'h2;
    e = ref_lookup(1);
    check("pin3_len", e.match_len, 0); check("pin3_ptr", e.pointer, 0); check("pin3_to", e.timeout, 0);
    exp_q.push_back(e);
    send_name(1, 1'b0);
    wait_valid(cyc);
    check("latency_one_probe", cyc, 2);
    accept_result(0);

    // 4: level never matches nor stops -> probe limit
    clear_tree();
    lvl_never = 1'b1;
    name_buf[0] = 32'h55;
    e = ref_lookup(1);
    check("pin4_len", e.match_len, 0); check("pin4_to", e.timeout, 1);
    exp_q.push_back(e);
    send_name(1, 1'b0);
    wait_valid(cyc);
    check("latency_probe_limit", cyc, 2 * MAXP);
    accept_result(0);

    // 5: consumer stalls for 5 cycles
    tree_three_words();
    exp_q.push_back(ref_lookup(3));
    send_name(3, 1'b1);
    accept_result(5);

    // 6: reset while the walk is in CAPTURE
    clear_tree();
    lvl_never = 1'b1;
    name_buf[0] = 32'h77;
    send_name(1, 1'b0);
    @(posedge clk_in); #1;
    check("busy_before_abort", bus.busy_out, 1);
    rst_in = 1'b1;
    #1;
    check_all_zero("abort");
    exp_q.delete();
    accepted_since_rst = 0;
    repeat (2) @(posedge clk_in);
    #1; rst_in = 1'b0;
    tree_three_words();
    exp_q.push_back(ref_lookup(3));
    send_name(3, 1'b0);
    accept_result(1);

    // randomized trees over a small alphabet so matches, dead ends and cycles all occur
    for (int t = 0; t < 40; t++) begin
      int n;
      clear_tree();
      for (int a = 0; a < 256; a++) begin
        node_word[a]    = 32'($urandom_range(0, 3));
        node_next[a]    = 16'($urandom_range(0, 255));
        node_nochild[a] = ($urandom_range(0, 4) == 0);
      end
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) name_buf[i] = 32'($urandom_range(0, 3));
      exp_q.push_back(ref_lookup(n));
      send_name(n, 1'b1);
      accept_result($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin @(posedge clk_in); #1; end
    end

    check("results_outstanding", exp_q.size(), 0);
`ifdef FIB_LOOKUP_STATS_EN
    check("stat_lookups_count", stat_lookups, accepted_since_rst);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
